// File: rtl/controlador_eventos_botoes.sv
// Push-button front end: two-flop sync and debounce for each button, press-to-event capture,
// and a round-robin valid/ack offer of pending presses to the processor.

module botao_lane #(
  parameter int                       COUNTER_WIDTH = 16,
  parameter logic [COUNTER_WIDTH-1:0] COUNTER_MAX   = '1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic botao,
  output logic filtrado,
  output logic press
);
  logic [1:0]               sync;
  logic [COUNTER_WIDTH-1:0] cnt;
  logic                     s, differ, accept;

  assign s      = sync[1];
  assign differ = s ^ filtrado;
  assign accept = differ && (cnt == COUNTER_MAX);
  // Asserted on the edge where the debounced level rises, so the pending bit is set on that edge too.
  assign press  = accept & s;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync     <= '0;
      cnt      <= '0;
      filtrado <= 1'b0;
    end else begin
      sync <= {sync[0], botao};
      if (!differ) begin
        cnt <= '0;
      end else if (accept) begin
        filtrado <= s;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module controlador_eventos_botoes #(
  parameter int                       NUM_BOTOES    = 4,
  parameter int                       COUNTER_WIDTH = 16,
  parameter logic [COUNTER_WIDTH-1:0] COUNTER_MAX   = 16'hFFFF,
  parameter int                       ID_WIDTH      = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_BOTOES-1:0] botoes,
  output logic [NUM_BOTOES-1:0] botoes_filtrados,
  output logic                  evento_valido,
  output logic [ID_WIDTH-1:0]   evento_id,
  input  logic                  evento_ack,
  output logic [NUM_BOTOES-1:0] eventos_pendentes,
  output logic                  evento_perdido
);
  typedef enum logic {OCIOSO, OFERTA} estado_t;

  localparam logic [ID_WIDTH:0]   N_EXT  = (ID_WIDTH+1)'(NUM_BOTOES);
  localparam logic [ID_WIDTH-1:0] ID_MAX = ID_WIDTH'(NUM_BOTOES-1);

  estado_t               estado, estado_next;
  logic [NUM_BOTOES-1:0] filt, press, pend, grant_clr;
  logic [ID_WIDTH-1:0]   ptr, id_r, grant_id;
  logic [ID_WIDTH:0]     idx;
  logic                  grant_any, grant_fire, ack_fire, perdido;

  genvar g;
  generate
    for (g = 0; g < NUM_BOTOES; g++) begin : g_lane
      botao_lane #(
        .COUNTER_WIDTH(COUNTER_WIDTH),
        .COUNTER_MAX  (COUNTER_MAX)
      ) u_lane (
        .clock   (clock),
        .reset_n (reset_n),
        .botao   (botoes[g]),
        .filtrado(filt[g]),
        .press   (press[g])
      );
    end
  endgenerate

  // Scanning downwards lets the candidate closest to ptr (in wrap order) win.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int k = NUM_BOTOES-1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (ID_WIDTH+1)'(k);
      if (idx >= N_EXT) idx = idx - N_EXT;
      if (pend[idx[ID_WIDTH-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = idx[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    estado_next = estado;
    grant_fire  = 1'b0;
    ack_fire    = 1'b0;
    case (estado)
      OCIOSO: if (grant_any) begin
        grant_fire  = 1'b1;
        estado_next = OFERTA;
      end
      OFERTA: if (evento_ack) begin
        ack_fire    = 1'b1;
        estado_next = OCIOSO;
      end
      default: estado_next = OCIOSO;
    endcase
  end

  assign grant_clr = grant_fire ? ({{(NUM_BOTOES-1){1'b0}}, 1'b1} << grant_id) : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado  <= OCIOSO;
      id_r    <= '0;
      ptr     <= '0;
      pend    <= '0;
      perdido <= 1'b0;
    end else begin
      estado <= estado_next;
      if (grant_fire) id_r <= grant_id;
      if (ack_fire)   ptr  <= (id_r == ID_MAX) ? '0 : id_r + 1'b1;
      // A new press beats a same-edge grant clear; only a press onto a still-pending bit is lost.
      pend <= (pend & ~grant_clr) | press;
      if (|(press & pend & ~grant_clr)) perdido <= 1'b1;
    end
  end

  assign botoes_filtrados  = filt;
  assign evento_valido     = (estado == OFERTA);
  assign evento_id         = id_r;
  assign eventos_pendentes = pend;
  assign evento_perdido    = perdido;
endmodule

// File: tb/tb_controlador_eventos_botoes.sv
// Directed plus random stimulus for the button event controller, checked cycle by cycle
// against a behavioural model built from the debounce, press and round-robin rules.

module tb_controlador_eventos_botoes;
  localparam int N    = 4;
  localparam int MAXC = 3;
  localparam int IDW  = 2;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   botoes;
  logic [N-1:0]   botoes_filtrados;
  logic           evento_valido;
  logic [IDW-1:0] evento_id;
  logic           evento_ack;
  logic [N-1:0]   eventos_pendentes;
  logic           evento_perdido;

  int n_assert = 0;
  int n_fail   = 0;

  // model state
  bit m_sy1[N], m_sy2[N], m_filt[N], m_pend[N];
  int m_cnt[N];
  bit m_off, m_lost;
  int m_id, m_ptr;

  controlador_eventos_botoes #(
    .NUM_BOTOES   (N),
    .COUNTER_WIDTH(16),
    .COUNTER_MAX  (16'd3),
    .ID_WIDTH     (IDW)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .botoes           (botoes),
    .botoes_filtrados (botoes_filtrados),
    .evento_valido    (evento_valido),
    .evento_id        (evento_id),
    .evento_ack       (evento_ack),
    .eventos_pendentes(eventos_pendentes),
    .evento_perdido   (evento_perdido)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_sy1[i] = 0; m_sy2[i] = 0; m_filt[i] = 0; m_pend[i] = 0; m_cnt[i] = 0;
    end
    m_off = 0; m_lost = 0; m_id = 0; m_ptr = 0;
  endfunction

  // One clock edge of the behavioural model, using the inputs present at the edge.
  function automatic void model_step();
    bit pr[N];
    bit found;
    int gi;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      pr[i] = 0;
      if (m_sy2[i] != m_filt[i]) begin
        if (m_cnt[i] < MAXC) m_cnt[i]++;
        else begin
          m_filt[i] = m_sy2[i];
          m_cnt[i]  = 0;
          pr[i]     = m_sy2[i];
        end
      end else m_cnt[i] = 0;
      m_sy2[i] = m_sy1[i];
      m_sy1[i] = botoes[i];
    end
    if (!m_off) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        gi = (m_ptr + k) % N;
        if (!found && m_pend[gi]) begin
          found = 1; m_off = 1; m_id = gi; m_pend[gi] = 0;
        end
      end
    end else if (evento_ack) begin
      m_off = 0;
      m_ptr = (m_id + 1) % N;
    end
    for (int i = 0; i < N; i++)
      if (pr[i]) begin
        if (m_pend[i]) m_lost = 1;
        m_pend[i] = 1;
      end
  endfunction

  task automatic check_all(input string tag);
    logic [N-1:0] ef, ep;
    for (int i = 0; i < N; i++) begin
      ef[i] = m_filt[i];
      ep[i] = m_pend[i];
    end
    chk({tag, ".filtrados"}, 32'(botoes_filtrados), 32'(ef));
    chk({tag, ".pendentes"}, 32'(eventos_pendentes), 32'(ep));
    chk({tag, ".valido"}, 32'(evento_valido), 32'(m_off));
    chk({tag, ".id"}, 32'(evento_id), 32'(m_id));
    chk({tag, ".perdido"}, 32'(evento_perdido), 32'(m_lost));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input string tag);
    int c = 0;
    do begin
      tick();
      c++;
    end while (!evento_valido && c < 40);
    chk({tag, ".wait_valid"}, 32'(evento_valido), 32'd1);
  endtask

  task automatic ack_one();
    evento_ack = 1'b1;
    tick();
    evento_ack = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    botoes     = '0;
    evento_ack = 1'b0;
    model_reset();
    #1;
    chk("reset.filtrados", 32'(botoes_filtrados), 32'd0);
    chk("reset.valido", 32'(evento_valido), 32'd0);
    chk("reset.pendentes", 32'(eventos_pendentes), 32'd0);
    chk("reset.perdido", 32'(evento_perdido), 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(3);

    // clean press of button 1
    botoes[1] = 1'b1;
    idle(5);
    chk("clean.filt_e5", 32'(botoes_filtrados), 32'd0);
    tick();
    chk("clean.filt_e6", 32'(botoes_filtrados), 32'b0010);
    chk("clean.pend_e6", 32'(eventos_pendentes), 32'b0010);
    chk("clean.valid_e6", 32'(evento_valido), 32'd0);
    tick();
    chk("clean.valid_e7", 32'(evento_valido), 32'd1);
    chk("clean.id_e7", 32'(evento_id), 32'd1);
    ack_one();
    chk("clean.valid_ack", 32'(evento_valido), 32'd0);
    botoes[1] = 1'b0;
    idle(10);
    chk("clean.release", 32'(evento_valido), 32'd0);

    // bounce on button 0
    for (int i = 0; i < 10; i++) begin
      botoes[0] = ~botoes[0];
      idle(2);
    end
    botoes[0] = 1'b0;
    idle(8);
    chk("bounce.filt", 32'(botoes_filtrados), 32'd0);
    chk("bounce.valid", 32'(evento_valido), 32'd0);

    // move ptr to 0 via button 3
    botoes[3] = 1'b1;
    wait_valid("p3");
    chk("p3.id", 32'(evento_id), 32'd3);
    ack_one();
    botoes[3] = 1'b0;
    idle(10);

    // round robin 0 and 2, then 1 and 3
    botoes = 4'b0101;
    wait_valid("rr0");
    chk("rr0.id", 32'(evento_id), 32'd0);
    ack_one();
    wait_valid("rr2");
    chk("rr2.id", 32'(evento_id), 32'd2);
    ack_one();
    botoes = '0;
    idle(10);
    botoes = 4'b1010;
    wait_valid("rr3");
    chk("rr3.id", 32'(evento_id), 32'd3);
    ack_one();
    wait_valid("rr1");
    chk("rr1.id", 32'(evento_id), 32'd1);
    ack_one();
    botoes = '0;
    idle(10);

    // lost press on button 3, never acked
    for (int p = 0; p < 3; p++) begin
      botoes[3] = 1'b1;
      idle(8);
      if (p < 2) begin
        botoes[3] = 1'b0;
        idle(8);
      end
    end
    chk("lost.perdido", 32'(evento_perdido), 32'd1);
    chk("lost.pend", 32'(eventos_pendentes), 32'b1000);
    chk("lost.valid", 32'(evento_valido), 32'd1);
    chk("lost.id", 32'(evento_id), 32'd3);

    // asynchronous reset mid-offer with button 2 held
    botoes = 4'b0100;
    idle(2);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst.valid", 32'(evento_valido), 32'd0);
    chk("arst.filt", 32'(botoes_filtrados), 32'd0);
    chk("arst.pend", 32'(eventos_pendentes), 32'd0);
    chk("arst.perdido", 32'(evento_perdido), 32'd0);
    @(negedge clock);
    idle(2);
    reset_n = 1'b1;
    idle(MAXC + 3);
    chk("arst.lat_early", 32'(evento_valido), 32'd0);
    tick();
    chk("arst.lat_valid", 32'(evento_valido), 32'd1);
    chk("arst.lat_id", 32'(evento_id), 32'd2);
    ack_one();
    botoes = '0;
    idle(10);

    // ack while idle must not move ptr (now 3)
    evento_ack = 1'b1;
    tick();
    evento_ack = 1'b0;
    tick();
    chk("misuse.valid", 32'(evento_valido), 32'd0);
    botoes = 4'b1001;
    wait_valid("mis3");
    chk("misuse.id_first", 32'(evento_id), 32'd3);
    ack_one();
    wait_valid("mis0");
    chk("misuse.id_second", 32'(evento_id), 32'd0);
    ack_one();
    botoes = '0;
    idle(10);

    // random buttons and acks
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        int b;
        b = $urandom_range(0, N-1);
        botoes[b] = ~botoes[b];
      end
      evento_ack = 1'($urandom_range(0, 1));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/controlador_eventos_botoes.md
Name: controlador_eventos_botoes

Overview:
Front-end controller for the board push-buttons. It synchronises and debounces NUM_BOTOES raw button inputs and turns each debounced press (0->1) into a pending event. A round-robin arbiter hands the pending events to the processor one at a time over a valid/ack handshake. The processor's input logic uses it as a single shared "button event" source.

Parameters:
NUM_BOTOES, 4, number of button inputs (2..16)
COUNTER_WIDTH, 16, width of each per-button stability counter
COUNTER_MAX, 16'hFFFF, number of consecutive differing cycles before a level change is accepted
ID_WIDTH, 2, width of evento_id; must equal ceil(log2(NUM_BOTOES))

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
botoes  in  NUM_BOTOES  raw, noisy, asynchronous button levels (1 = pressed)
botoes_filtrados  out  NUM_BOTOES  debounced levels
evento_valido  out  1  an event is offered on evento_id
evento_id  out  ID_WIDTH  index of the button whose press is offered
evento_ack  in  1  processor accepts the offered event
eventos_pendentes  out  NUM_BOTOES  pending-press bitmap
evento_perdido  out  1  sticky flag: a press was dropped

Behaviour:
- Reset: while reset_n = 0, all registers clear asynchronously. This covers the sync flops, counters, botoes_filtrados, pending bits, evento_valido, evento_id, the round-robin pointer and evento_perdido. FSM returns to OCIOSO.
- Sync: each botoes[i] passes through 2 flops before any other use.
- Debounce (per button, on the synchronised level s):
  - If s != filtrado[i] and cnt < COUNTER_MAX: cnt <= cnt+1.
  - If s != filtrado[i] and cnt == COUNTER_MAX: filtrado[i] <= s and cnt <= 0.
  - If s == filtrado[i]: cnt <= 0, so any bounce restarts the count.
- Latency: raw level stable from sampling edge 1 updates botoes_filtrados on edge COUNTER_MAX+3.
- Press detection:
  - On the edge where filtrado[i] goes 0->1, pendente[i] <= 1.
  - Releases (1->0) generate nothing.
  - If pendente[i] is already 1 when a new press arrives, the press is dropped and evento_perdido <= 1. evento_perdido stays set until reset.
- Arbiter FSM, 2 states:
  - OCIOSO: evento_valido = 0. If any pendente is set, grant the first set index scanning ptr, ptr+1, ... wrapping modulo NUM_BOTOES. On that edge: evento_id <= index, pendente[index] <= 0, evento_valido <= 1, go to OFERTA.
  - OFERTA: evento_valido = 1 and evento_id is held stable. When evento_ack = 1: evento_valido <= 0, ptr <= (evento_id+1) mod NUM_BOTOES, go to OCIOSO.
- Handshake rules:
  - evento_ack is ignored in OCIOSO.
  - ack and valid are sampled on the same edge.
  - Maximum throughput is 1 event per 2 cycles.
  - A pending event is offered on the edge after its pending bit is set.
- Simultaneous events:
  - Grant clearing pendente[i] on the same edge a new press of i sets it: the set wins and no loss is flagged.
  - A press of the button currently being offered sets its pending bit normally.
- eventos_pendentes mirrors the pending bits and excludes the event currently offered.

Test Plan:
- Clean press (COUNTER_MAX=3, N=4): botoes[1] 0->1 and held → botoes_filtrados[1]=1 after edge 6, pendentes=0010. evento_valido=1 with id=1 after edge 7. ack on edge 8 → valid=0 and ptr=2. Release produces no event.
- Bounce: botoes[0] toggles every 2 cycles for 20 cycles, then returns to 0 → botoes_filtrados stays 0000, evento_valido never rises.
- Round robin:
  - Buttons 0 and 2 pressed simultaneously with ptr=0 → id 0 is offered and acked, then id 2. ptr ends at 3.
  - Buttons 1 and 3 pressed next → id 3 first, then id 1.
- Lost press: press, release, press, release, press button 3 without ever acking → first event offered, second held pending, third dropped. evento_perdido=1, pendentes=1000.
- Reset mid-offer: assert reset_n=0 while evento_valido=1 and botoes[2] is held high → valid, filtrados, pendentes and perdido go to 0 immediately, without waiting for a clock edge. After release of reset, a fresh press event for id 2 appears COUNTER_MAX+4 edges later.
- Ack misuse: pulse evento_ack while OCIOSO with no pending events → no state change and ptr unchanged.
